// File: rtl/tjmono_hit_assembler_if.sv
// Handshake bundles for the TJ-Monopix hit assembler: receiver FIFO pop side
// and decoded hit record side.
`timescale 1ns/1ps

interface tjmono_fifo_if;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic        FIFO_READ;

    modport master (output FIFO_EMPTY, FIFO_DATA, input FIFO_READ);
    modport slave  (input FIFO_EMPTY, FIFO_DATA, output FIFO_READ);
endinterface

interface tjmono_hit_if;
    logic        HIT_VALID;
    logic        HIT_READY;
    logic [5:0]  HIT_COL;
    logic [8:0]  HIT_ROW;
    logic [5:0]  HIT_LE;
    logic [5:0]  HIT_TE;
    logic [5:0]  HIT_TOT;
    logic        HIT_NOISE;
    logic [51:0] HIT_TS;
    logic [3:0]  HIT_TOKEN_LSB;

    modport master (output HIT_VALID, HIT_COL, HIT_ROW, HIT_LE, HIT_TE, HIT_TOT,
                           HIT_NOISE, HIT_TS, HIT_TOKEN_LSB,
                    input  HIT_READY);
    modport slave  (input  HIT_VALID, HIT_COL, HIT_ROW, HIT_LE, HIT_TE, HIT_TOT,
                           HIT_NOISE, HIT_TS, HIT_TOKEN_LSB,
                    output HIT_READY);
endinterface

// File: rtl/tjmono_hit_assembler.sv
// Pops TJ-Monopix receiver words, checks id/index sequence and reassembles each
// 4-word group into one decoded hit record behind a valid/ready slot.
`timescale 1ns/1ps

module tjmono_hit_assembler #(
    parameter logic [1:0]  IDENTYFIER = 2'b00,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              BUS_CLK,
    input  logic              BUS_RST_N,
    input  logic              EN,
    input  logic              CLR_CNT,
    tjmono_fifo_if.slave      fifo,
    tjmono_hit_if.master      hit,
    output logic [CNT_W-1:0]  SEQ_ERR_CNT,
    output logic [CNT_W-1:0]  ID_ERR_CNT,
    output logic [31:0]       HIT_CNT
);

    localparam int unsigned PL_W  = 28;
    localparam int unsigned TS_W  = 52;
    localparam int unsigned COL_W = 6;
    localparam int unsigned ROW_W = 9;
    localparam int unsigned TDC_W = 6;
    localparam int unsigned TOK_W = 4;

    typedef enum logic [1:0] {W0, W1, W2, W3} state_t;

    state_t            state_q, state_d;
    logic              rd_c;
    logic              cap0_c, cap1_c, cap2_c, load_c, seq_err_c, id_err_c;
    logic [1:0]        w_id, w_idx;
    logic [PL_W-1:0]   w_pl;

    logic [COL_W-1:0]  cap_col;
    logic [ROW_W-1:0]  cap_row;
    logic [TDC_W-1:0]  cap_le, cap_te;
    logic              cap_noise;
    logic [TS_W-1:0]   cap_ts;
    logic [TOK_W-1:0]  cap_tok;

    logic              valid_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [TDC_W-1:0]  le_q, te_q, tot_q;
    logic              noise_q;
    logic [TS_W-1:0]   ts_q;
    logic [TOK_W-1:0]  tok_q;

    assign w_id  = fifo.FIFO_DATA[31:30];
    assign w_idx = fifo.FIFO_DATA[29:28];
    assign w_pl  = fifo.FIFO_DATA[PL_W-1:0];

    // Only the closing word stalls on a full output slot; reset also blocks pops.
    assign rd_c = EN & BUS_RST_N & ~fifo.FIFO_EMPTY
                & ~((state_q == W3) & valid_q & ~hit.HIT_READY);
    assign fifo.FIFO_READ = rd_c;

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) state_q <= W0;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cap0_c    = 1'b0;
        cap1_c    = 1'b0;
        cap2_c    = 1'b0;
        load_c    = 1'b0;
        seq_err_c = 1'b0;
        id_err_c  = 1'b0;
        if (rd_c) begin
            if (w_id != IDENTYFIER) begin
                id_err_c = 1'b1;
            end else if (w_idx == 2'(state_q)) begin
                case (state_q)
                    W0:      begin cap0_c = 1'b1; state_d = W1; end
                    W1:      begin cap1_c = 1'b1; state_d = W2; end
                    W2:      begin cap2_c = 1'b1; state_d = W3; end
                    default: begin load_c = 1'b1; state_d = W0; end
                endcase
            end else begin
                seq_err_c = 1'b1;
                if (w_idx == 2'b00) begin
                    cap0_c  = 1'b1;
                    state_d = W1;
                end else begin
                    state_d = W0;
                end
            end
        end
    end

    // Partial-group capture registers
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            cap_col   <= '0;
            cap_row   <= '0;
            cap_te    <= '0;
            cap_le    <= '0;
            cap_noise <= 1'b0;
            cap_ts    <= '0;
            cap_tok   <= '0;
        end else begin
            if (cap0_c) begin
                cap_col   <= w_pl[5:0];
                cap_row   <= w_pl[14:6];
                cap_te    <= w_pl[20:15];
                cap_le    <= w_pl[26:21];
                cap_noise <= w_pl[27];
            end
            if (cap1_c) cap_ts[27:0] <= w_pl;
            if (cap2_c) begin
                cap_ts[51:28] <= w_pl[23:0];
                cap_tok       <= w_pl[27:24];
            end
        end
    end

    // Output slot: a load on the same edge as a handshake keeps VALID high
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            valid_q <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            le_q    <= '0;
            te_q    <= '0;
            tot_q   <= '0;
            noise_q <= 1'b0;
            ts_q    <= '0;
            tok_q   <= '0;
        end else if (load_c) begin
            valid_q <= 1'b1;
            col_q   <= cap_col;
            row_q   <= cap_row;
            le_q    <= cap_le;
            te_q    <= cap_te;
            tot_q   <= cap_te - cap_le;
            noise_q <= cap_noise;
            ts_q    <= cap_ts;
            tok_q   <= cap_tok;
        end else if (valid_q && hit.HIT_READY) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            SEQ_ERR_CNT <= '0;
            ID_ERR_CNT  <= '0;
            HIT_CNT     <= '0;
        end else if (CLR_CNT) begin
            SEQ_ERR_CNT <= '0;
            ID_ERR_CNT  <= '0;
            HIT_CNT     <= '0;
        end else begin
            if (seq_err_c && (SEQ_ERR_CNT != '1)) SEQ_ERR_CNT <= SEQ_ERR_CNT + CNT_W'(1);
            if (id_err_c && (ID_ERR_CNT != '1))   ID_ERR_CNT  <= ID_ERR_CNT + CNT_W'(1);
            if (load_c)                           HIT_CNT     <= HIT_CNT + 32'd1;
        end
    end

    assign hit.HIT_VALID     = valid_q;
    assign hit.HIT_COL       = col_q;
    assign hit.HIT_ROW       = row_q;
    assign hit.HIT_LE        = le_q;
    assign hit.HIT_TE        = te_q;
    assign hit.HIT_TOT       = tot_q;
    assign hit.HIT_NOISE     = noise_q;
    assign hit.HIT_TS        = ts_q;
    assign hit.HIT_TOKEN_LSB = tok_q;

endmodule

// File: tb/tb_tjmono_hit_assembler.sv
// Bench for tjmono_hit_assembler: queue-based FIFO source, word-stream reference
// model, directed scenarios plus a randomized phase.
`timescale 1ns/1ps

module tb_tjmono_hit_assembler;

    typedef struct packed {
        logic [5:0]  col;
        logic [8:0]  row;
        logic [5:0]  le;
        logic [5:0]  te;
        logic [5:0]  tot;
        logic        noise;
        logic [51:0] ts;
        logic [3:0]  tok;
    } hit_t;

    logic        BUS_CLK   = 1'b0;
    logic        BUS_RST_N = 1'b0;
    logic        EN        = 1'b0;
    logic        CLR_CNT   = 1'b0;
    logic [7:0]  SEQ_ERR_CNT, ID_ERR_CNT;
    logic [31:0] HIT_CNT;

    tjmono_fifo_if fifo_bus ();
    tjmono_hit_if  hit_bus ();

    tjmono_hit_assembler #(.IDENTYFIER(2'b00), .CNT_W(8)) dut (
        .BUS_CLK     (BUS_CLK),
        .BUS_RST_N   (BUS_RST_N),
        .EN          (EN),
        .CLR_CNT     (CLR_CNT),
        .fifo        (fifo_bus),
        .hit         (hit_bus),
        .SEQ_ERR_CNT (SEQ_ERR_CNT),
        .ID_ERR_CNT  (ID_ERR_CNT),
        .HIT_CNT     (HIT_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] fifo_q[$];
    hit_t        exp_q[$];

    // Reference model state: expected index, pending fields, counters
    int          m_idx = 0;
    int          m_seq = 0;
    int          m_id  = 0;
    logic [31:0] m_hits = 0;
    int          p_col, p_row, p_te, p_le, p_noise, p_tok;
    longint      p_ts_lo, p_ts_hi;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int id, input int idx, input logic [27:0] p);
        return {2'(id), 2'(idx), p};
    endfunction

    function automatic void take_word0(input int p);
        p_col   = p % 64;
        p_row   = (p / 64) % 512;
        p_te    = (p / 32768) % 64;
        p_le    = (p / 2097152) % 64;
        p_noise = (p / 134217728) % 2;
    endfunction

    function automatic void feed(input logic [31:0] w);
        int   id, idx, p;
        hit_t h;
        id  = int'(w[31:30]);
        idx = int'(w[29:28]);
        p   = int'(w[27:0]);
        if (id != 0) begin
            if (m_id < 255) m_id++;
            return;
        end
        if (idx != m_idx) begin
            if (m_seq < 255) m_seq++;
            if (idx == 0) begin
                take_word0(p);
                m_idx = 1;
            end else begin
                m_idx = 0;
            end
            return;
        end
        case (idx)
            0: take_word0(p);
            1: p_ts_lo = longint'(p);
            2: begin
                p_ts_hi = longint'(p % 16777216);
                p_tok   = p / 16777216;
            end
            default: begin
                h.col   = 6'(p_col);
                h.row   = 9'(p_row);
                h.le    = 6'(p_le);
                h.te    = 6'(p_te);
                h.tot   = 6'((p_te - p_le + 64) % 64);
                h.noise = 1'(p_noise);
                h.ts    = 52'(p_ts_hi * 64'd268435456 + p_ts_lo);
                h.tok   = 4'(p_tok);
                exp_q.push_back(h);
                m_hits = m_hits + 32'd1;
            end
        endcase
        m_idx = (m_idx + 1) % 4;
    endfunction

    function automatic hit_t obs_hit();
        hit_t h;
        h.col   = hit_bus.HIT_COL;
        h.row   = hit_bus.HIT_ROW;
        h.le    = hit_bus.HIT_LE;
        h.te    = hit_bus.HIT_TE;
        h.tot   = hit_bus.HIT_TOT;
        h.noise = hit_bus.HIT_NOISE;
        h.ts    = hit_bus.HIT_TS;
        h.tok   = hit_bus.HIT_TOKEN_LSB;
        return h;
    endfunction

    task automatic drive_fifo();
        fifo_bus.FIFO_EMPTY = (fifo_q.size() == 0);
        fifo_bus.FIFO_DATA  = (fifo_q.size() == 0) ? 32'd0 : fifo_q[0];
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    task automatic push_group(input logic [27:0] p0, input logic [27:0] p1, input logic [27:0] p2);
        push(wd(0, 0, p0));
        push(wd(0, 1, p1));
        push(wd(0, 2, p2));
        push(wd(0, 3, 28'($urandom)));
    endtask

    task automatic m_reset();
        exp_q.delete();
        fifo_q.delete();
        m_idx  = 0;
        m_seq  = 0;
        m_id   = 0;
        m_hits = 0;
        drive_fifo();
    endtask

    // One clock: check at negedge, advance model at posedge, re-drive FIFO after
    task automatic tick();
        logic        pop, hs, clr, exp_rd;
        logic [31:0] w;
        @(negedge BUS_CLK);
        exp_rd = BUS_RST_N && EN && (fifo_q.size() > 0)
                 && !((m_idx == 3) && (exp_q.size() > 0) && !hit_bus.HIT_READY);
        chk("fifo_read", 128'(fifo_bus.FIFO_READ), 128'(exp_rd));
        chk("hit_valid", 128'(hit_bus.HIT_VALID), 128'(exp_q.size() > 0));
        if (hit_bus.HIT_VALID && exp_q.size() > 0)
            chk("hit_record", 128'(obs_hit()), 128'(exp_q[0]));
        pop = fifo_bus.FIFO_READ;
        hs  = hit_bus.HIT_VALID && hit_bus.HIT_READY;
        clr = CLR_CNT;
        w   = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
        @(posedge BUS_CLK);
        if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
        if (pop && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            feed(w);
        end
        if (clr) begin
            m_seq  = 0;
            m_id   = 0;
            m_hits = 0;
        end
        #1;
        drive_fifo();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        hit_bus.HIT_READY = 1'b1;
        while ((fifo_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_leftover", 128'(fifo_q.size() + exp_q.size()), 128'(0));
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_seq"}, 128'(SEQ_ERR_CNT), 128'(m_seq));
        chk({tag, "_id"},  128'(ID_ERR_CNT),  128'(m_id));
        chk({tag, "_hit"}, 128'(HIT_CNT),     128'(m_hits));
    endtask

    task automatic clear_counters();
        CLR_CNT = 1'b1;
        tick();
        CLR_CNT = 1'b0;
    endtask

    task automatic push_rand_group();
        int r, drop;
        logic [31:0] w;
        r    = $urandom_range(0, 9);
        drop = $urandom_range(0, 3);
        for (int k = 0; k < 4; k++) begin
            w = wd(0, k, 28'($urandom));
            if (r == 1 && k == drop) push(wd($urandom_range(1, 3), $urandom_range(0, 3), 28'($urandom)));
            if (r == 2 && k == drop) w[29:28] = 2'($urandom);
            if (!(r == 0 && k == drop)) push(w);
        end
    endtask

    initial begin
        int n;
        hit_bus.HIT_READY = 1'b0;
        drive_fifo();
        EN = 1'b1;

        // Reset state; a queued group must not be popped while in reset
        push_group(28'h5A6F8C3, 28'h1234567, 28'hABCDEF9);
        #12;
        chk("rst_fifo_read", 128'(fifo_bus.FIFO_READ), 128'(0));
        chk("rst_valid", 128'(hit_bus.HIT_VALID), 128'(0));
        chk("rst_fields", 128'(obs_hit()), 128'(0));
        chk("rst_seq", 128'(SEQ_ERR_CNT), 128'(0));
        chk("rst_hitcnt", 128'(HIT_CNT), 128'(0));
        @(posedge BUS_CLK);
        #1;
        BUS_RST_N = 1'b1;

        hit_bus.HIT_READY = 1'b1;
        drain(40);
        check_counters("basic");
        chk("basic_hitcnt_lit", 128'(HIT_CNT), 128'(1));

        // Directed field values with a held record
        hit_bus.HIT_READY = 1'b0;
        push_group(28'hDAF8C83, 28'h1234567, 28'hABCDEF9);
        n = 0;
        while (!hit_bus.HIT_VALID && n < 20) begin tick(); n++; end
        chk("lit_valid", 128'(hit_bus.HIT_VALID), 128'(1));
        chk("lit_col",   128'(hit_bus.HIT_COL),   128'(6'h03));
        chk("lit_row",   128'(hit_bus.HIT_ROW),   128'(9'h032));
        chk("lit_te",    128'(hit_bus.HIT_TE),    128'(6'h1F));
        chk("lit_le",    128'(hit_bus.HIT_LE),    128'(6'h2D));
        chk("lit_noise", 128'(hit_bus.HIT_NOISE), 128'(1));
        chk("lit_tot",   128'(hit_bus.HIT_TOT),   128'(6'h32));
        chk("lit_ts",    128'(hit_bus.HIT_TS),    128'(52'hBCDEF91234567));
        chk("lit_tok",   128'(hit_bus.HIT_TOKEN_LSB), 128'(4'hA));
        drain(40);
        chk("lit_hitcnt", 128'(HIT_CNT), 128'(2));
        chk("lit_err", 128'({SEQ_ERR_CNT, ID_ERR_CNT}), 128'(0));

        // 00,01,00,01,10,11
        clear_counters();
        push(wd(0, 0, 28'($urandom)));
        push(wd(0, 1, 28'($urandom)));
        push_group(28'($urandom), 28'($urandom), 28'($urandom));
        drain(40);
        check_counters("restart00");
        chk("restart00_seq_lit", 128'(SEQ_ERR_CNT), 128'(1));
        chk("restart00_hit_lit", 128'(HIT_CNT), 128'(1));

        // 00,10,00,01,10,11
        clear_counters();
        push(wd(0, 0, 28'($urandom)));
        push(wd(0, 2, 28'($urandom)));
        push_group(28'($urandom), 28'($urandom), 28'($urandom));
        drain(40);
        check_counters("skip10");
        chk("skip10_seq_lit", 128'(SEQ_ERR_CNT), 128'(1));
        chk("skip10_hit_lit", 128'(HIT_CNT), 128'(1));

        // Foreign word between 01 and 10, carrying a wrong index as well
        clear_counters();
        push(wd(0, 0, 28'($urandom)));
        push(wd(0, 1, 28'($urandom)));
        push(wd(2, 0, 28'($urandom)));
        push(wd(0, 2, 28'($urandom)));
        push(wd(0, 3, 28'($urandom)));
        drain(40);
        check_counters("foreign");
        chk("foreign_id_lit", 128'(ID_ERR_CNT), 128'(1));
        chk("foreign_seq_lit", 128'(SEQ_ERR_CNT), 128'(0));

        // Back-pressure with two groups queued
        clear_counters();
        hit_bus.HIT_READY = 1'b0;
        push_group(28'($urandom), 28'($urandom), 28'($urandom));
        push_group(28'($urandom), 28'($urandom), 28'($urandom));
        repeat (12) tick();
        chk("stall_words_left", 128'(fifo_q.size()), 128'(1));
        chk("stall_hitcnt", 128'(HIT_CNT), 128'(1));
        hit_bus.HIT_READY = 1'b1;
        tick();
        hit_bus.HIT_READY = 1'b0;
        tick();
        chk("no_gap_valid", 128'(hit_bus.HIT_VALID), 128'(1));
        chk("no_gap_hitcnt", 128'(HIT_CNT), 128'(2));
        drain(40);

        // Error counter saturation and clear
        clear_counters();
        for (int i = 0; i < 255; i++) push(wd(0, 1, 28'($urandom)));
        drain(400);
        chk("sat_255", 128'(SEQ_ERR_CNT), 128'(8'hFF));
        for (int i = 0; i < 5; i++) push(wd(0, 1, 28'($urandom)));
        drain(40);
        chk("sat_hold", 128'(SEQ_ERR_CNT), 128'(8'hFF));
        check_counters("sat");
        clear_counters();
        chk("clr_seq", 128'(SEQ_ERR_CNT), 128'(0));

        // EN dropped mid-group keeps the partial capture
        push(wd(0, 0, 28'($urandom)));
        push(wd(0, 1, 28'($urandom)));
        repeat (3) tick();
        EN = 1'b0;
        push(wd(0, 2, 28'($urandom)));
        push(wd(0, 3, 28'($urandom)));
        repeat (5) tick();
        chk("en_off_words_left", 128'(fifo_q.size()), 128'(2));
        EN = 1'b1;
        drain(40);
        check_counters("en_pause");

        // Randomized traffic: corrupted groups, EN gaps, back-pressure, clears
        for (int c = 0; c < 800; c++) begin
            if (fifo_q.size() < 6) push_rand_group();
            EN                = ($urandom_range(0, 7) != 0);
            hit_bus.HIT_READY = 1'($urandom_range(0, 1));
            CLR_CNT           = ($urandom_range(0, 99) == 0);
            tick();
        end
        CLR_CNT = 1'b0;
        EN      = 1'b1;
        push_group(28'($urandom), 28'($urandom), 28'($urandom));
        drain(200);
        check_counters("random");

        // Async reset with a held record and a partial group
        hit_bus.HIT_READY = 1'b0;
        push_group(28'($urandom), 28'($urandom), 28'($urandom));
        push(wd(0, 0, 28'($urandom)));
        push(wd(0, 1, 28'($urandom)));
        n = 0;
        while (fifo_q.size() > 0 && n < 30) begin tick(); n++; end
        chk("pre_rst_valid", 128'(hit_bus.HIT_VALID), 128'(1));
        push(wd(0, 2, 28'($urandom)));
        #2;
        BUS_RST_N = 1'b0;
        #1;
        chk("arst_fifo_read", 128'(fifo_bus.FIFO_READ), 128'(0));
        chk("arst_valid", 128'(hit_bus.HIT_VALID), 128'(0));
        chk("arst_fields", 128'(obs_hit()), 128'(0));
        chk("arst_counters", 128'({SEQ_ERR_CNT, ID_ERR_CNT, HIT_CNT}), 128'(0));
        m_reset();
        push(wd(0, 2, 28'($urandom)));
        repeat (2) tick();
        BUS_RST_N = 1'b1;
        m_reset();
        push_group(28'($urandom), 28'($urandom), 28'($urandom));
        drain(40);
        check_counters("post_rst");
        chk("post_rst_hit_lit", 128'(HIT_CNT), 128'(1));
        chk("post_rst_seq_lit", 128'(SEQ_ERR_CNT), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
